// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request/write-port bundle for the instruction encoder
interface instr_encoder_if #(
  parameter int IMM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  valid_i;
  logic                  ready_o;
  logic [2:0]            imm_src_i;
  logic [IMM_WIDTH-1:0]  imm_i;
  logic [6:0]            opcode_i;
  logic [4:0]            rd_i;
  logic [4:0]            rs1_i;
  logic [4:0]            rs2_i;
  logic [2:0]            funct3_i;
  logic [6:0]            funct7_i;
  logic                  addr_load_i;
  logic [ADDR_WIDTH-1:0] addr_val_i;
  logic                  we_o;
  logic                  ready_i;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [IMM_WIDTH-1:0]  instr_o;
  logic                  err_o;
  logic [15:0]           count_o;

  // Loader side: presents fields and accepts memory writes
  modport master (
    output valid_i, imm_src_i, imm_i, opcode_i, rd_i, rs1_i, rs2_i,
           funct3_i, funct7_i, addr_load_i, addr_val_i, ready_i,
    input  ready_o, we_o, addr_o, instr_o, err_o, count_o
  );

  // Encoder side
  modport slave (
    input  valid_i, imm_src_i, imm_i, opcode_i, rd_i, rs1_i, rs2_i,
           funct3_i, funct7_i, addr_load_i, addr_val_i, ready_i,
    output ready_o, we_o, addr_o, instr_o, err_o, count_o
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs RISC-V fields into a word and writes it to instruction memory
module instr_encoder #(
  parameter int                    IMM_WIDTH  = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic           clk_i,
  input logic           rst_i,
  instr_encoder_if.slave bus
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_J = 3'b011;
  localparam logic [2:0] SRC_U = 3'b100;
  localparam logic [2:0] SRC_R = 3'b101;

  logic [IMM_WIDTH-1:0]  imm;
  logic [IMM_WIDTH-1:0]  word;
  logic                  legal;
  logic                  accept;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;

  logic                  we_r;
  logic                  err_r;
  logic [IMM_WIDTH-1:0]  instr_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [15:0]           count_r;

  assign imm       = bus.imm_i;
  assign accept    = bus.valid_i && bus.ready_o;
  assign handshake = we_r && bus.ready_i;
  // Word alignment is enforced by masking the low two bits of a loaded address
  assign load_addr = bus.addr_val_i & ~ADDR_WIDTH'(3);
  assign wr_addr   = bus.addr_load_i ? load_addr : next_addr;

  assign bus.ready_o = !we_r || bus.ready_i;
  assign bus.we_o    = we_r;
  assign bus.err_o   = err_r;
  assign bus.instr_o = instr_r;
  assign bus.addr_o  = addr_r;
  assign bus.count_o = count_r;

  // Scatter the fields by format and decide whether the immediate fits the format
  always_comb begin
    word       = '0;
    legal      = 1'b0;
    word[6:0]  = bus.opcode_i;
    case (bus.imm_src_i)
      SRC_I: begin
        word[11:7]  = bus.rd_i;
        word[14:12] = bus.funct3_i;
        word[19:15] = bus.rs1_i;
        word[31:20] = imm[11:0];
        legal       = (&imm[31:11]) || !(|imm[31:11]);
      end
      SRC_S: begin
        word[11:7]  = imm[4:0];
        word[14:12] = bus.funct3_i;
        word[19:15] = bus.rs1_i;
        word[24:20] = bus.rs2_i;
        word[31:25] = imm[11:5];
        legal       = (&imm[31:11]) || !(|imm[31:11]);
      end
      SRC_B: begin
        word[7]     = imm[11];
        word[11:8]  = imm[4:1];
        word[14:12] = bus.funct3_i;
        word[19:15] = bus.rs1_i;
        word[24:20] = bus.rs2_i;
        word[30:25] = imm[10:5];
        word[31]    = imm[12];
        legal       = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
      end
      SRC_J: begin
        word[11:7]  = bus.rd_i;
        word[19:12] = imm[19:12];
        word[20]    = imm[11];
        word[30:21] = imm[10:1];
        word[31]    = imm[20];
        legal       = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
      end
      SRC_U: begin
        word[11:7]  = bus.rd_i;
        word[31:12] = imm[31:12];
        legal       = !(|imm[11:0]);
      end
      SRC_R: begin
        word[11:7]  = bus.rd_i;
        word[14:12] = bus.funct3_i;
        word[19:15] = bus.rs1_i;
        word[24:20] = bus.rs2_i;
        word[31:25] = bus.funct7_i;
        legal       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Single output stage: drain on handshake, refill on legal accept, flag drops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_r      <= 1'b0;
      err_r     <= 1'b0;
      instr_r   <= '0;
      addr_r    <= '0;
      next_addr <= BASE_ADDR;
      count_r   <= '0;
    end else begin
      if (handshake) begin
        we_r    <= 1'b0;
        count_r <= count_r + 16'd1;
      end
      if (accept && legal) begin
        we_r      <= 1'b1;
        instr_r   <= word;
        addr_r    <= wr_addr;
        next_addr <= wr_addr + ADDR_WIDTH'(4);
      end else begin
        if (accept) err_r <= 1'b1;
        if (bus.addr_load_i) next_addr <= load_addr;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V instruction encoder: the inverse of the core's immediate decode path. It accepts instruction fields plus a 32-bit immediate and an immediate-type code over a valid/ready handshake, then packs them into a 32-bit instruction word. It range-checks the immediate and writes the word to instruction memory at an auto-incrementing address. It sits between the debug/boot loader and the instruction-memory write port, so programs can be patched or loaded without a pre-assembled image.

## Interface
- IMM_WIDTH, 32, width of immediate input and instruction word
- ADDR_WIDTH, 32, width of instruction-memory byte address
- BASE_ADDR, 0, write address after reset
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  input fields valid
- ready_o  out  1  encoder can accept input this cycle
- imm_src_i  in  3  type: 000 I, 001 S, 010 B, 011 J, 100 U, 101 R (no immediate); 110/111 illegal
- imm_i  in  IMM_WIDTH  immediate value (two's complement, byte offset for B/J, full value for U)
- opcode_i  in  7  opcode field
- rd_i, rs1_i, rs2_i  in  5 each  register fields
- funct3_i  in  3  funct3 field
- funct7_i  in  7  funct7 field (R-type only)
- addr_load_i  in  1  load next write address from addr_val_i
- addr_val_i  in  ADDR_WIDTH  new address; bits [1:0] ignored (forced 0)
- we_o  out  1  instruction-memory write request (valid)
- ready_i  in  1  instruction memory accepts write
- addr_o  out  ADDR_WIDTH  write address
- instr_o  out  IMM_WIDTH  encoded instruction
- err_o  out  1  sticky: an unencodable request was dropped
- count_o  out  16  instructions written (output handshakes), wraps at 0xFFFF→0

## Operation
- Encoding, always: instr[6:0]=opcode.
- rd → [11:7] for all types except S and B.
- funct3 → [14:12] and rs1 → [19:15] for all types except U and J.
- rs2 → [24:20] for S, B and R.
- I: [31:20]=imm[11:0].
- S: [31:25]=imm[11:5], [11:7]=imm[4:0].
- B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- U: [31:12]=imm[31:12].
- R: [31:25]=funct7.
- Legality; the request is illegal if any of these fails:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: always legal.
  - 110/111: always illegal.
- Output register is a single stage.
  - Legal accept: load instr_o, set addr_o = next_addr, set we_o=1.
  - Illegal accept: the request is consumed, we_o is not set, err_o is set, next_addr is unchanged.
- next_addr is an internal counter, reset to BASE_ADDR. It advances by 4 on each legal accept and wraps modulo 2^ADDR_WIDTH.
- addr_load_i:
  - Without an accept: next_addr = addr_val_i.
  - Same cycle as a legal accept: the accepted word uses addr_val_i and next_addr = addr_val_i+4 (load wins).
  - A pending write (we_o=1) keeps its latched addr_o.
- err_o clears only on reset.

## Timing
- Reset values: we_o=0, instr_o=0, addr_o=0, err_o=0, count_o=0, next_addr=BASE_ADDR, ready_o=1.
- ready_o = !we_o || ready_i (combinational; back-to-back acceptance at one word per cycle when memory is ready).
- Accept occurs on rising edge with valid_i && ready_o.
  - Legal: we_o/instr_o/addr_o are valid the next cycle (latency 1).
  - Illegal: err_o goes high the next cycle.
- Output handshake is we_o && ready_i.
  - count_o increments on that edge.
  - we_o drops unless a new legal accept occurs on the same edge; in that case we_o stays 1 with the new word.
- While we_o && !ready_i: instr_o and addr_o are held stable, ready_o=0, and inputs are ignored.
- Illegal accept while draining a word (ready_i=1): the old word completes, we_o falls, err_o rises.
- Reset mid-write: the pending word is discarded with no write, and all state returns to reset values on that edge.

## Test plan
- I-type: imm_src=000, opcode=0010011, rd=1, rs1=0, funct3=0, imm=5, ready_i=1 → next cycle we_o=1, instr_o=0x00500093, addr_o=0x0; count_o=1 after handshake.
- B-type: imm_src=010, opcode=1100011, funct3=001, rs1=1, rs2=0, imm=0xFFFFFFFC → instr_o=0xFE009EE3; U-type imm_src=100, opcode=0110111, rd=5, imm=0x12345000 → instr_o=0x123452B7 at addr 0x4.
- Illegal: J-type imm=3, then I-type imm=0x800 → neither written, we_o stays 0, err_o=1 from cycle after first accept, next legal word lands at the unchanged address.
- Backpressure: ready_i=0, two back-to-back valid words → first held on instr_o/addr_o with ready_o=0 for N cycles; release → writes at 0x0 then 0x4, count_o=2, no word lost or duplicated.
- Address load: addr_load_i=1, addr_val_i=0x103 in the same cycle as a legal accept → addr_o=0x100; the next word writes at 0x104.
- Reset mid-write: we_o=1, ready_i=0, assert rst_i → next cycle we_o=0, err_o=0, count_o=0; next word writes at BASE_ADDR.
